// File: rtl/ecc_ram_scrubber.sv
// ecc_ram_scrubber: background scrubber for a soft-ECC RAM port.
// It walks every address, reads the word, and writes the decoder-corrected
// data back when a single-bit error was corrected. Uncorrectable words are
// logged. The RAM port is shared with user logic through an external arbiter
// using a req/gnt handshake.
// Optional feature macro: ECC_SCRUB_STATS_EN enables corr_cnt, uncorr_cnt and
// uncorr_addr. Without it those outputs are tied to 0 and have no registers.
module ecc_ram_scrubber #(
    parameter int NUM_WORDS      = 512,
    parameter int ADDR_WIDTH     = 9,
    parameter int DATA_BITS      = 16,
    parameter int RAM_RD_LATENCY = 4,
    parameter int SCRUB_INTERVAL = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    output logic                  ram_req,
    input  logic                  ram_gnt,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_wren,
    output logic [DATA_BITS-1:0]  ram_wdata,
    input  logic [DATA_BITS-1:0]  ram_q,
    input  logic [2:0]            ram_err,
    output logic                  busy,
    output logic                  sweep_done,
    output logic                  uncorr_irq,
    output logic [ADDR_WIDTH-1:0] uncorr_addr,
    output logic [15:0]           corr_cnt,
    output logic [15:0]           uncorr_cnt
);

    localparam int WAIT_W   = (SCRUB_INTERVAL > 0) ? $clog2(SCRUB_INTERVAL + 1) : 1;
    localparam int LAT_W    = (RAM_RD_LATENCY > 2) ? $clog2(RAM_RD_LATENCY - 1) : 1;
    localparam int LAT_LOAD = (RAM_RD_LATENCY > 2) ? RAM_RD_LATENCY - 2 : 0;

    localparam logic [WAIT_W-1:0]     WAIT_INIT = WAIT_W'(SCRUB_INTERVAL);
    localparam logic [LAT_W-1:0]      LAT_INIT  = LAT_W'(LAT_LOAD);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_CHECK,
        ST_WB_REQ,
        ST_NEXT
    } state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [WAIT_W-1:0]     wait_q;
    logic [LAT_W-1:0]      lat_q;
    logic                  req_q;
    logic                  wren_q;
    logic [DATA_BITS-1:0]  wdata_q;
    logic                  busy_q;
    logic                  sweep_q;
    logic                  irq_q;

    // err[0] (any error seen) is implied by [1]/[2]; the scrubber never needs it.
    logic unused_err0;
    assign unused_err0 = ram_err[0];

    // Scrub FSM. Request/write-enable are registered on state entry so the
    // address and direction presented to the arbiter cannot change until the
    // grant arrives; the pointer only moves in ST_NEXT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            wait_q  <= '0;
            lat_q   <= '0;
            req_q   <= 1'b0;
            wren_q  <= 1'b0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            sweep_q <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            sweep_q <= 1'b0;
            irq_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (enable) begin
                        state_q <= ST_WAIT;
                        wait_q  <= WAIT_INIT;
                        busy_q  <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (wait_q == '0) begin
                        state_q <= ST_RD_REQ;
                        req_q   <= 1'b1;
                        wren_q  <= 1'b0;
                    end else begin
                        wait_q <= wait_q - WAIT_W'(1);
                    end
                end
                ST_RD_REQ: begin
                    // The grant cycle is the read access itself.
                    if (ram_gnt) begin
                        req_q <= 1'b0;
                        if (RAM_RD_LATENCY <= 1) begin
                            state_q <= ST_CHECK;
                        end else begin
                            state_q <= ST_RD_WAIT;
                            lat_q   <= LAT_INIT;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    // RAM_RD_LATENCY-1 cycles here puts ST_CHECK on the data-valid cycle.
                    if (lat_q == '0) begin
                        state_q <= ST_CHECK;
                    end else begin
                        lat_q <= lat_q - LAT_W'(1);
                    end
                end
                ST_CHECK: begin
                    // Uncorrectable wins even when the corrected flag is also set.
                    if (ram_err[2]) begin
                        irq_q   <= 1'b1;
                        state_q <= ST_NEXT;
                    end else if (ram_err[1]) begin
                        wdata_q <= ram_q;
                        req_q   <= 1'b1;
                        wren_q  <= 1'b1;
                        state_q <= ST_WB_REQ;
                    end else begin
                        state_q <= ST_NEXT;
                    end
                end
                ST_WB_REQ: begin
                    if (ram_gnt) begin
                        req_q   <= 1'b0;
                        wren_q  <= 1'b0;
                        state_q <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (ptr_q == LAST_ADDR) begin
                        ptr_q   <= '0;
                        sweep_q <= 1'b1;
                    end else begin
                        ptr_q <= ptr_q + ADDR_WIDTH'(1);
                    end
                    if (enable) begin
                        state_q <= ST_WAIT;
                        wait_q  <= WAIT_INIT;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                    wren_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ram_req    = req_q;
    assign ram_wren   = wren_q;
    assign ram_addr   = ptr_q;
    assign ram_wdata  = wdata_q;
    assign busy       = busy_q;
    assign sweep_done = sweep_q;
    assign uncorr_irq = irq_q;

`ifdef ECC_SCRUB_STATS_EN
    logic [15:0]           corr_cnt_q;
    logic [15:0]           uncorr_cnt_q;
    logic [ADDR_WIDTH-1:0] uncorr_addr_q;

    // Error statistics, updated on the check cycle; counters stick at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_cnt_q    <= '0;
            uncorr_cnt_q  <= '0;
            uncorr_addr_q <= '0;
        end else if (state_q == ST_CHECK) begin
            if (ram_err[2]) begin
                uncorr_addr_q <= ptr_q;
                if (uncorr_cnt_q != 16'hFFFF) uncorr_cnt_q <= uncorr_cnt_q + 16'd1;
            end else if (ram_err[1]) begin
                if (corr_cnt_q != 16'hFFFF) corr_cnt_q <= corr_cnt_q + 16'd1;
            end
        end
    end

    assign corr_cnt    = corr_cnt_q;
    assign uncorr_cnt  = uncorr_cnt_q;
    assign uncorr_addr = uncorr_addr_q;
`else
    assign corr_cnt    = '0;
    assign uncorr_cnt  = '0;
    assign uncorr_addr = '0;
`endif

endmodule

// File: tb/tb_ecc_ram_scrubber.sv
// Testbench for ecc_ram_scrubber: behavioural RAM with a fixed read latency
// and per-address error injection, random grant patterns, and a word-walk
// reference model that predicts the access sequence, pulses and statistics.
module tb_ecc_ram_scrubber;

    localparam int NW  = 16;
    localparam int AW  = 4;
    localparam int DB  = 16;
    localparam int LAT = 4;

`ifdef ECC_SCRUB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          ram_req;
    logic          ram_gnt = 1'b1;
    logic [AW-1:0] ram_addr;
    logic          ram_wren;
    logic [DB-1:0] ram_wdata;
    logic [DB-1:0] ram_q = '0;
    logic [2:0]    ram_err = '0;
    logic          busy;
    logic          sweep_done;
    logic          uncorr_irq;
    logic [AW-1:0] uncorr_addr;
    logic [15:0]   corr_cnt;
    logic [15:0]   uncorr_cnt;

    ecc_ram_scrubber #(
        .NUM_WORDS(NW), .ADDR_WIDTH(AW), .DATA_BITS(DB),
        .RAM_RD_LATENCY(LAT), .SCRUB_INTERVAL(0)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .ram_req(ram_req), .ram_gnt(ram_gnt), .ram_addr(ram_addr),
        .ram_wren(ram_wren), .ram_wdata(ram_wdata), .ram_q(ram_q),
        .ram_err(ram_err), .busy(busy), .sweep_done(sweep_done),
        .uncorr_irq(uncorr_irq), .uncorr_addr(uncorr_addr),
        .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural RAM ----------------
    typedef struct packed { logic wr; logic [AW-1:0] addr; logic [DB-1:0] data; } acc_t;
    typedef struct { int cyc; logic [AW-1:0] addr; } rd_t;

    logic [DB-1:0] mem     [NW];
    logic [2:0]    err_tab [NW];
    rd_t           pend[$];
    acc_t          act_q[$];
    int            cyc = 0;
    int            gnt_mode = 0;     // 0: gnt_force, 1: random, 2: grant reads only
    logic          gnt_force = 1'b1;
    int            n_rd = 0, n_sweep = 0, n_irq = 0, n_proto = 0;
    logic          p_req = 1'b0, p_gnt = 1'b0, p_wren = 1'b0;
    logic [AW-1:0] p_addr = '0;

    // Read data is only meaningful on the exact cycle LAT after the grant;
    // every other cycle carries noise so a mistimed sample is caught.
    always @(posedge clk) begin
        #1;
        cyc++;
        while (pend.size() > 0 && pend[0].cyc + LAT < cyc) void'(pend.pop_front());
        if (pend.size() > 0 && pend[0].cyc + LAT == cyc) begin
            ram_q   = mem[pend[0].addr];
            ram_err = err_tab[pend[0].addr];
            void'(pend.pop_front());
        end else begin
            ram_q   = DB'($urandom);
            ram_err = 3'($urandom);
        end
        case (gnt_mode)
            1:       ram_gnt = ($urandom_range(0, 2) != 0);
            2:       ram_gnt = !ram_wren;
            default: ram_gnt = gnt_force;
        endcase
    end

    // Access monitor and handshake-protocol watch, mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            p_req = 1'b0;
        end else begin
            if (ram_req && ram_gnt) begin
                act_q.push_back('{ram_wren, ram_addr, ram_wren ? ram_wdata : '0});
                if (!ram_wren) begin
                    pend.push_back('{cyc, ram_addr});
                    n_rd++;
                end else begin
                    err_tab[ram_addr] = 3'b000;
                end
            end
            if (sweep_done) n_sweep++;
            if (uncorr_irq) n_irq++;
            if (p_req && !p_gnt && (!ram_req || ram_addr != p_addr || ram_wren != p_wren))
                n_proto++;
            p_req = ram_req; p_gnt = ram_gnt; p_addr = ram_addr; p_wren = ram_wren;
        end
    end

    // ---------------- reference model ----------------
    int      exp_ptr = 0, exp_corr = 0, exp_unc = 0, exp_uaddr = 0;

    function automatic int st(input int v);
        return STATS ? v : 0;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, "_req"},   32'(ram_req), 0);
        chk({tag, "_wren"},  32'(ram_wren), 0);
        chk({tag, "_addr"},  32'(ram_addr), 0);
        chk({tag, "_wdata"}, 32'(ram_wdata), 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_sweep"}, 32'(sweep_done), 0);
        chk({tag, "_irq"},   32'(uncorr_irq), 0);
        chk({tag, "_uaddr"}, 32'(uncorr_addr), 0);
        chk({tag, "_ccnt"},  32'(corr_cnt), 0);
        chk({tag, "_ucnt"},  32'(uncorr_cnt), 0);
    endtask

    // Scrub n words starting from the model pointer, then stop and compare.
    task automatic run_words(input string tag, input int n);
        acc_t     exp_q[$];
        logic [2:0] e [NW];
        int base_rd, base_sw, base_irq, x_sw, x_irq, t;
        for (int a = 0; a < NW; a++) e[a] = err_tab[a];
        x_sw = 0; x_irq = 0;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{1'b0, AW'(exp_ptr), '0});
            if (e[exp_ptr][2]) begin
                x_irq++;
                exp_unc   = (exp_unc < 65535) ? exp_unc + 1 : 65535;
                exp_uaddr = exp_ptr;
            end else if (e[exp_ptr][1]) begin
                exp_q.push_back('{1'b1, AW'(exp_ptr), mem[exp_ptr]});
                exp_corr = (exp_corr < 65535) ? exp_corr + 1 : 65535;
                e[exp_ptr] = 3'b000;
            end
            if (exp_ptr == NW - 1) x_sw++;
            exp_ptr = (exp_ptr + 1) % NW;
        end
        act_q.delete();
        base_rd = n_rd; base_sw = n_sweep; base_irq = n_irq;
        enable = 1'b1;
        t = 0;
        while (n_rd - base_rd < n && t < n * 60 + 100) begin
            @(negedge clk); #1; t++;
        end
        chk({tag, "_rd_timeout"}, 32'(n_rd - base_rd >= n), 1);
        enable = 1'b0;
        t = 0;
        while (busy && t < 200) begin
            @(negedge clk); #1; t++;
        end
        chk({tag, "_idle"}, 32'(busy), 0);
        chk({tag, "_nacc"}, act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            chk({tag, "_acc_wr"},   32'(act_q[i].wr),   32'(exp_q[i].wr));
            chk({tag, "_acc_addr"}, 32'(act_q[i].addr), 32'(exp_q[i].addr));
            chk({tag, "_acc_data"}, 32'(act_q[i].data), 32'(exp_q[i].data));
        end
        chk({tag, "_sweeps"}, n_sweep - base_sw, x_sw);
        chk({tag, "_irqs"},   n_irq - base_irq, x_irq);
        chk({tag, "_ccnt"},   32'(corr_cnt), st(exp_corr));
        chk({tag, "_ucnt"},   32'(uncorr_cnt), st(exp_unc));
        chk({tag, "_uaddr"},  32'(uncorr_addr), st(exp_uaddr));
    endtask

    initial begin
        int t;
        for (int a = 0; a < NW; a++) begin
            mem[a] = DB'($urandom);
            err_tab[a] = 3'b000;
        end
        repeat (3) @(negedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Clean sweep
        run_words("clean", 16);

        // Corrected at 5, uncorrectable at 9, both flags at 3
        mem[5] = 16'h1234;
        err_tab[5] = 3'b011;
        err_tab[9] = 3'b101;
        err_tab[3] = 3'b111;
        run_words("errs", 16);
        chk("errs_ccnt_abs", 32'(corr_cnt),    STATS ? 1 : 0);
        chk("errs_ucnt_abs", 32'(uncorr_cnt),  STATS ? 2 : 0);
        chk("errs_uaddr_abs", 32'(uncorr_addr), STATS ? 9 : 0);

        // Grant withheld for 10+ cycles in the read request at addr 2
        err_tab[3] = 3'b000;
        err_tab[9] = 3'b000;
        run_words("pre_stall", 2);
        gnt_force = 1'b0;
        enable = 1'b1;
        repeat (12) begin @(negedge clk); #1; end
        chk("stall_req",  32'(ram_req), 1);
        chk("stall_addr", 32'(ram_addr), 2);
        chk("stall_wren", 32'(ram_wren), 0);
        gnt_force = 1'b1;
        run_words("stall", 1);

        // Stop mid-word and resume at the next address
        run_words("resume_a", 5);
        run_words("resume_b", 4);

        // Reset while a write-back waits for its grant
        err_tab[exp_ptr] = 3'b011;
        gnt_mode = 2;
        act_q.delete();
        enable = 1'b1;
        t = 0;
        while (!ram_wren && t < 200) begin @(negedge clk); #1; t++; end
        chk("wb_reach", 32'(ram_wren), 1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero("midrst");
        t = 0;
        foreach (act_q[i]) if (act_q[i].wr) t++;
        chk("midrst_nowrite", t, 0);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        pend.delete();
        rst = 1'b0;
        gnt_mode = 0;
        exp_ptr = 0; exp_corr = 0; exp_unc = 0; exp_uaddr = 0;
        run_words("post_rst", 16);

        // Randomized error patterns with random grant stalls
        gnt_mode = 1;
        for (int it = 0; it < 6; it++) begin
            for (int a = 0; a < NW; a++) begin
                mem[a] = DB'($urandom);
                err_tab[a] = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            end
            run_words("rand", $urandom_range(4, 24));
        end

        chk("protocol", n_proto, 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
